register: RTL and testbench

- Single-word storage register attached to a shared, tri-stated datapath bus. It is the general-purpose register element of the bus-based datapath.
- Loads the bus value on a clock edge when R_in is asserted.
- Drives its stored value back onto the same bus while R_out is asserted.
- Releases the bus (high impedance) at all other times so other bus agents can drive it.

---
 rtl/register.sv | 27 ++
 tb/tb_register.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/register.sv
// General-purpose datapath register on a shared tri-state bus.
// Captures the bus on R_in, drives its word back while R_out is high.
module register #(
    parameter int                WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             R_in,
    input  logic             R_out,
    inout  wire [WIDTH-1:0] bus
);

    logic [WIDTH-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (R_in) begin
            q <= bus;
        end
    end

    // Released bus is high impedance so other agents can drive it.
    assign bus = R_out ? q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_register.sv
// Scoreboard bench for the tri-state bus register.
// Stimulus pushes expected bus values; a negedge monitor pops and checks.
module tb_register;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         r_in = 1'b0;
    logic         r_out = 1'b0;
    logic         tb_en = 1'b0;
    logic [W-1:0] tb_drv = '0;
    wire  [W-1:0] bus;

    assign bus = tb_en ? tb_drv : {W{1'bz}};

    register #(.WIDTH(W), .RESET_VALUE(16'h0000)) dut (
        .clk  (clk),
        .rst  (rst),
        .R_in (r_in),
        .R_out(r_out),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] exp;
        bit           chk;
        string        name;
    } exp_t;

    exp_t q_exp[$];
    int checks = 0;
    int failures = 0;

    // Reference: the stored word as a plain value plus a "known" flag.
    logic [W-1:0] m_val = '0;
    bit           m_known = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (r_out || tb_en) begin
            if (q_exp.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL underflow: bus presented with no expectation");
            end else begin
                e = q_exp.pop_front();
                if (e.chk) begin
                    checks++;
                    if (bus !== e.exp) begin
                        failures++;
                        $display("FAIL %s: bus=%h expected=%h t=%0t",
                                 e.name, bus, e.exp, $time);
                    end
                end
            end
        end
    end

    task automatic cyc(input bit s_rst, input bit s_in, input bit s_out,
                       input bit s_en, input logic [W-1:0] s_drv,
                       input string name);
        exp_t e;
        rst = s_rst;
        r_in = s_in;
        r_out = s_out;
        tb_en = s_en;
        tb_drv = s_drv;
        if (s_out || s_en) begin
            e.name = name;
            if (s_en && !s_out) begin
                e.exp = s_drv;
                e.chk = 1'b1;
            end else if (s_out && !s_en) begin
                e.exp = m_val;
                e.chk = m_known;
            end else begin
                e.exp = '0;
                e.chk = 1'b0;
            end
            q_exp.push_back(e);
        end
        @(posedge clk);
        if (s_rst) begin
            m_val = 16'h0000;
            m_known = 1'b1;
        end else if (s_in) begin
            if (s_en && !s_out) begin
                m_val = s_drv;
                m_known = 1'b1;
            end else if (s_out && !s_en) begin
                m_val = m_val;
            end else begin
                m_known = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        logic [W-1:0] d;
        bit a, b, c, en;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, '0, "reset");
        cyc(0, 0, 0, 0, '0, "idle");
        cyc(0, 1, 0, 1, 16'h0005, "load_drive");
        cyc(0, 0, 0, 0, '0, "idle");
        cyc(0, 0, 1, 0, '0, "read_5");
        cyc(0, 0, 0, 1, 16'h5A5A, "released_after_read");
        cyc(1, 0, 0, 0, '0, "rereset");
        cyc(0, 0, 1, 0, '0, "read_after_rereset");
        cyc(0, 1, 0, 1, 16'h0077, "load_77");
        cyc(1, 0, 1, 0, '0, "read_during_reset");
        cyc(0, 0, 1, 0, '0, "read_after_reset_edge");
        cyc(1, 1, 0, 1, 16'hABCD, "rst_priority");
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 1, 16'h1234, "hold_drive");
        cyc(0, 0, 1, 0, '0, "hold_read");
        cyc(0, 1, 0, 1, 16'h00F0, "load_F0");
        cyc(0, 1, 1, 0, '0, "simul_1");
        cyc(0, 1, 1, 0, '0, "simul_2");
        cyc(0, 0, 1, 0, '0, "simul_after");
        for (int i = 0; i < 400; i++) begin
            d = W'($urandom);
            a = ($urandom_range(0, 19) == 0);
            b = $urandom_range(0, 1) == 1;
            c = $urandom_range(0, 2) == 0;
            en = !c && ($urandom_range(0, 1) == 1);
            cyc(a, b, c, en, d, "random");
        end
        cyc(0, 0, 0, 0, '0, "drain");
        @(negedge clk);
        #1;
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL leftover: queue=%0d expected=0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
